rsa_xcel_param_mod_exp: RTL and testbench

//  Self-contained, width-parametrised modular exponentiation unit: result = b^e mod n.

---
 rtl/rsa_xcel_param_mod_exp.sv | 97 +++++++++
 tb/tb_rsa_xcel_param_mod_exp.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rsa_xcel_param_mod_exp.sv
// rsa_xcel_param_mod_exp: b^e mod n via right-to-left square-and-multiply with two bit-serial interleaved mod-multipliers
module rsa_xcel_param_mod_exp #(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3*NBITS-1:0] istream_msg,
  input  logic               istream_val,
  output logic               istream_rdy,
  output logic [NBITS-1:0]   ostream_msg,
  output logic               ostream_err,
  output logic               ostream_val,
  input  logic               ostream_rdy
);
  localparam int CW = $clog2(NBITS);
  typedef enum logic [1:0] {IDLE, REDUCE, STEP, DONE} state_t;
  state_t state, state_nx;
  logic [NBITS-1:0] n, e, b, r, n_in;
  logic [NBITS:0] acc_a, acc_b, t_a, t_b;
  logic [CW-1:0] cnt;
  logic err, fire, last;
  // One interleaved step: double, reduce, conditionally add y, reduce; stays below 2n so NBITS+1 bits suffice
  function automatic logic [NBITS:0] mm(input logic [NBITS:0] acc, input logic xb,
                                        input logic [NBITS:0] y, input logic [NBITS:0] nn);
    logic [NBITS:0] t;
    t = acc << 1;
    t = t >= nn ? t - nn : t;
    t = xb ? t + y : t;
    return t >= nn ? t - nn : t;
  endfunction
  assign n_in        = istream_msg[3*NBITS-1:2*NBITS];
  assign istream_rdy = state == IDLE;
  assign ostream_val = state == DONE;
  assign ostream_msg = r;
  assign ostream_err = err;
  assign fire        = istream_val && istream_rdy;
  assign last        = cnt == '0;
  // Both units scan b from MSB down; unit A multiplies by 1 while reducing b, by r while stepping
  always_comb begin
    t_a = mm(acc_a, b[cnt], {1'b0, state == REDUCE ? NBITS'(1) : r}, {1'b0, n});
    t_b = mm(acc_b, b[cnt], {1'b0, b}, {1'b0, n});
  end
  // Next-state logic; a pass ends when cnt reaches zero
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = fire ? (n_in < NBITS'(2) ? DONE : REDUCE) : IDLE;
      REDUCE:  state_nx = last ? (e == '0 ? DONE : STEP) : REDUCE;
      STEP:    state_nx = last && (e >> 1) == '0 ? DONE : STEP;
      DONE:    state_nx = ostream_rdy ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // Operand latch, per-cycle multiplier accumulation and end-of-pass writeback
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      n <= '0;
      e <= '0;
      b <= '0;
      r <= '0;
      err <= 1'b0;
      cnt <= '0;
      acc_a <= '0;
      acc_b <= '0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          n <= n_in;
          e <= istream_msg[2*NBITS-1:NBITS];
          b <= istream_msg[NBITS-1:0];
          r <= n_in < NBITS'(2) ? '0 : NBITS'(1);
          err <= n_in == '0;
          cnt <= CW'(NBITS-1);
          acc_a <= '0;
          acc_b <= '0;
        end
        REDUCE: begin
          cnt <= last ? CW'(NBITS-1) : cnt - 1'b1;
          acc_a <= last ? '0 : t_a;
          b <= last ? t_a[NBITS-1:0] : b;
        end
        STEP: begin
          cnt <= last ? CW'(NBITS-1) : cnt - 1'b1;
          acc_a <= last ? '0 : t_a;
          acc_b <= last ? '0 : t_b;
          r <= last && e[0] ? t_a[NBITS-1:0] : r;
          b <= last ? t_b[NBITS-1:0] : b;
          e <= last ? e >> 1 : e;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rsa_xcel_param_mod_exp.sv
// tb_rsa_xcel_param_mod_exp: scoreboard bench for 32-bit and 8-bit instances of the mod-exp core
module tb_rsa_xcel_param_mod_exp;
  localparam int W = 32;
  typedef struct {longint unsigned msg; bit err; int unsigned at;} exp_t;
  logic clk = 0, rst = 1;
  logic [3*W-1:0] imsg = '0;
  logic [W-1:0] omsg;
  logic ival = 0, irdy, oerr, oval, ordy = 0;
  logic [23:0] imsg8 = '0;
  logic [7:0] omsg8;
  logic ival8 = 0, irdy8, oerr8, oval8, ordy8 = 0;
  int unsigned cyc = 0;
  int vecs = 0, bad = 0;
  exp_t sb[$];
  rsa_xcel_param_mod_exp #(.NBITS(W)) dut (
    .clk(clk), .reset(rst), .istream_msg(imsg), .istream_val(ival), .istream_rdy(irdy),
    .ostream_msg(omsg), .ostream_err(oerr), .ostream_val(oval), .ostream_rdy(ordy));
  rsa_xcel_param_mod_exp #(.NBITS(8)) dut8 (
    .clk(clk), .reset(rst), .istream_msg(imsg8), .istream_val(ival8), .istream_rdy(irdy8),
    .ostream_msg(omsg8), .ostream_err(oerr8), .ostream_val(oval8), .ostream_rdy(ordy8));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    vecs++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic longint unsigned golden(input longint unsigned n, input longint unsigned e,
                                             input longint unsigned b);
    longint unsigned r = 1, bb = 0;
    if (n < 2) return 0;
    bb = b % n;
    while (e != 0) begin
      if (e[0]) r = r * bb % n;
      bb = bb * bb % n;
      e = e >> 1;
    end
    return r;
  endfunction
  function automatic int unsigned lat_of(input int nb, input longint unsigned n, input longint unsigned e);
    int k = 0;
    if (n < 2) return 1;
    while (e != 0) begin
      k++;
      e = e >> 1;
    end
    return nb * (k + 1) + 1;
  endfunction
  task automatic send(input bit w8, input longint unsigned n, input longint unsigned e,
                      input longint unsigned b, input longint unsigned exp_msg);
    int g = 0;
    @(negedge clk);
    while (!(w8 ? irdy8 : irdy) && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (w8) begin
      imsg8 = {n[7:0], e[7:0], b[7:0]};
      ival8 = 1;
    end else begin
      imsg = {n[31:0], e[31:0], b[31:0]};
      ival = 1;
    end
    @(posedge clk);
    #1;
    ival = 0;
    ival8 = 0;
    sb.push_back('{exp_msg, n == 0, cyc + lat_of(w8 ? 8 : W, n, e) - 1});
  endtask
  task automatic recv(input bit w8, input int hold);
    exp_t x;
    int g = 0;
    @(negedge clk);
    while (!(w8 ? oval8 : oval) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    x = sb.pop_front();
    if (g >= 3000) check("timeout", 0, 1);
    else begin
      check("msg", w8 ? omsg8 : omsg, x.msg);
      check("err", w8 ? oerr8 : oerr, x.err);
      check("latency", cyc, x.at);
      repeat (hold) begin
        @(negedge clk);
        check("hold_msg", w8 ? omsg8 : omsg, x.msg);
        check("hold_irdy", w8 ? irdy8 : irdy, 0);
        check("hold_oval", w8 ? oval8 : oval, 1);
      end
    end
    if (w8) ordy8 = 1; else ordy = 1;
    @(posedge clk);
    #1;
    ordy = 0;
    ordy8 = 0;
    @(negedge clk);
    check("idle_irdy", w8 ? irdy8 : irdy, 1);
    check("idle_oval", w8 ? oval8 : oval, 0);
  endtask
  task automatic req(input bit w8, input longint unsigned n, input longint unsigned e,
                     input longint unsigned b, input longint unsigned exp_msg, input int hold);
    send(w8, n, e, b, exp_msg);
    recv(w8, hold);
  endtask
  initial begin
    longint unsigned n, e, b;
    repeat (2) @(negedge clk);
    check("rst_irdy", irdy, 1);
    check("rst_oval", oval, 0);
    check("rst_msg", omsg, 0);
    check("rst_err", oerr, 0);
    check("rst_irdy8", irdy8, 1);
    rst = 0;
    req(0, 497, 13, 4, 445, 0);
    req(0, 7, 3, 10, 6, 0);
    req(0, 1000, 10, 2, 24, 0);
    req(0, 11, 0, 5, 1, 0);
    req(0, 0, 5, 3, 0, 0);
    req(0, 1, 9, 9, 0, 0);
    req(0, 497, 13, 4, 445, 20);
    req(1, 251, 2, 250, 1, 0);
    req(1, 255, 255, 254, 254, 0);
    send(0, 497, 13, 4, 445);
    repeat (60) @(negedge clk);
    #2 rst = 1;
    #1;
    check("midrst_irdy", irdy, 1);
    check("midrst_oval", oval, 0);
    check("midrst_msg", omsg, 0);
    check("midrst_err", oerr, 0);
    sb.delete();
    @(negedge clk);
    rst = 0;
    req(0, 497, 13, 4, 445, 0);
    for (int i = 0; i < 15; i++) begin
      n = i % 5 == 0 ? $urandom_range(0, 3) : $urandom;
      e = $urandom >> $urandom_range(0, 31);
      b = $urandom;
      req(0, n, e, b, golden(n, e, b), 0);
    end
    for (int i = 0; i < 20; i++) begin
      n = i % 7 == 0 ? $urandom_range(0, 2) : $urandom_range(0, 255);
      e = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      req(1, n, e, b, golden(n, e, b), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
